// File: rtl/riscv_pkg.sv
// Shared types for the write-back pipeline: stage record, write-back source
// encoding and the data-selection rule used at MEM/WB.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  // One in-flight instruction. In EX, data is not yet meaningful because the
  // ALU result arrives combinationally during that stage.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    wb_sel_t           wbsel;
    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   data;
  } stage_t;

  // Raw 2-bit decode field to enum; the reserved code behaves as ALU.
  function automatic wb_sel_t decodeWbSel(input logic [1:0] raw);
    wb_sel_t sel;
    unique case (raw)
      2'd1:    sel = WB_MEM;
      2'd2:    sel = WB_PC4;
      default: sel = WB_ALU;
    endcase
    return sel;
  endfunction

  // Final write-back value of an instruction sitting in MEM.
  function automatic logic [XLEN-1:0] resolveData(
    input wb_sel_t         wbsel,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] aluData,
    input logic [XLEN-1:0] memRdata
  );
    logic [XLEN-1:0] result;
    unique case (wbsel)
      WB_MEM:  result = memRdata;
      WB_PC4:  result = pc4;
      default: result = aluData;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/riscv_fwd_mux.sv
// Bypass selector for one decode source operand. Picks the youngest in-flight
// producer of the source register and reports a load-use hazard when that
// producer is a load still in EX.
module riscv_fwd_mux import riscv_pkg::*; (
  input  stage_t            exStage,
  input  stage_t            memStage,
  input  stage_t            wbStage,
  input  logic [XLEN-1:0]   exAlu,
  input  logic [XLEN-1:0]   memRdata,
  input  logic [REG_AW-1:0] srcAddr,
  output logic              fwdEn,
  output logic [XLEN-1:0]   fwdData,
  output logic              loadUse
);

  logic srcLive;
  logic exHit;
  logic memHit;
  logic wbHit;

  // x0 is hard-wired zero, so it never takes a bypass.
  assign srcLive = (srcAddr != '0);
  assign exHit   = srcLive & exStage.valid  & exStage.wen  & (exStage.rd  == srcAddr);
  assign memHit  = srcLive & memStage.valid & memStage.wen & (memStage.rd == srcAddr);
  assign wbHit   = srcLive & wbStage.valid  & wbStage.wen  & (wbStage.rd  == srcAddr);

  // Fields of the stage records this selector has no use for.
  logic unusedBits;
  assign unusedBits = ^{exStage.data, wbStage.wbsel, wbStage.pc4};

  // Youngest producer wins: EX, then MEM, then WB.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    fwdEn   = 1'b0;
    fwdData = '0;
    loadUse = 1'b0;
    if (exHit) begin
      fwdEn   = 1'b1;
      // A load in EX has no data yet; the ALU value passed here is not
      // meaningful and the hazard flag forces the consumer to wait a cycle.
      fwdData = (exStage.wbsel == WB_PC4) ? exStage.pc4 : exAlu;
      loadUse = (exStage.wbsel == WB_MEM);
    end else if (memHit) begin
      fwdEn   = 1'b1;
      fwdData = resolveData(memStage.wbsel, memStage.pc4, memStage.data, memRdata);
    end else if (wbHit) begin
      // Same value the regfile is being written with this cycle.
      fwdEn   = 1'b1;
      fwdData = wbStage.data;
    end
  end

endmodule

// File: rtl/riscv_wb_pipe.sv
// Destination-side pipeline from decode to the regfile write port. Carries
// each instruction's rd/wen/write-back source through EX, MEM and WB, drives
// the write port from WB, and supplies bypass data plus a load-use flag for
// the decode-stage source operands.
module riscv_wb_pipe import riscv_pkg::*; (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_wen_i,
  input  logic [1:0]        id_wbsel_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [XLEN-1:0]   ex_alu_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic [REG_AW-1:0] AddrD_o,
  output logic [XLEN-1:0]   DataD_o,
  output logic              RegWEn_o,
  output logic              fwd_a_en_o,
  output logic [XLEN-1:0]   fwd_a_o,
  output logic              fwd_b_en_o,
  output logic [XLEN-1:0]   fwd_b_o,
  output logic              load_use_o
);

  stage_t exQ, memQ, wbQ;
  stage_t exD, memD, wbD;
  logic   loadUseA, loadUseB;

  // Decode fields become the next EX entry; stall and flush both insert a bubble.
  always_comb begin
    exD       = '0;
    exD.valid = id_valid_i & ~stall_i & ~flush_i;
    exD.rd    = id_rd_i;
    exD.wen   = id_wen_i;
    exD.wbsel = decodeWbSel(id_wbsel_i);
    exD.pc4   = id_pc_i + XLEN'(4);
  end

  // EX moves to MEM with its ALU result; a taken branch kills the EX instruction.
  always_comb begin
    memD      = exQ;
    memD.data = ex_alu_i;
    if (flush_i) begin
      memD.valid = 1'b0;
    end
  end

  // MEM moves to WB with its final write-back value selected.
  always_comb begin
    wbD      = memQ;
    wbD.data = resolveData(memQ.wbsel, memQ.pc4, memQ.data, mem_rdata_i);
  end

  // Stage registers; stall never freezes them, it only starves EX.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of the one before it.
    if (rst_i) begin
      exQ  <= '0;
      memQ <= '0;
      wbQ  <= '0;
    end else begin
      exQ  <= exD;
      memQ <= memD;
      wbQ  <= wbD;
    end
  end

  // Regfile write port straight from WB; writes to x0 are suppressed here.
  assign RegWEn_o = wbQ.valid & wbQ.wen & (wbQ.rd != '0);
  assign AddrD_o  = wbQ.rd;
  assign DataD_o  = wbQ.data;

  riscv_fwd_mux fwdA (
    .exStage  (exQ),
    .memStage (memQ),
    .wbStage  (wbQ),
    .exAlu    (ex_alu_i),
    .memRdata (mem_rdata_i),
    .srcAddr  (id_rs1_i),
    .fwdEn    (fwd_a_en_o),
    .fwdData  (fwd_a_o),
    .loadUse  (loadUseA)
  );

  riscv_fwd_mux fwdB (
    .exStage  (exQ),
    .memStage (memQ),
    .wbStage  (wbQ),
    .exAlu    (ex_alu_i),
    .memRdata (mem_rdata_i),
    .srcAddr  (id_rs2_i),
    .fwdEn    (fwd_b_en_o),
    .fwdData  (fwd_b_o),
    .loadUse  (loadUseB)
  );

  // Only a real decode instruction can be held back by a load in EX.
  assign load_use_o = id_valid_i & (loadUseA | loadUseB);

endmodule

// File: doc/riscv_wb_pipe.md
Name: riscv_wb_pipe

Overview:
Write-side companion of riscv_regfile: carries each instruction's destination (AddrD, RegWEn, write-back source) from decode through EX and MEM to WB, and drives the regfile write port. The regfile is written 3 cycles after decode. It also compares decode-stage source addresses against the in-flight destinations, supplies bypass data for DataA/DataB, and flags load-use hazards. It sits between the decode/execute/memory datapath and the regfile write port.

Parameters:
XLEN, 32, data width
REG_AW, 5, register address width

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
stall_i  in  1  hold decode; insert bubble into EX
flush_i  in  1  kill the instructions in ID and EX (branch taken in EX)
id_valid_i  in  1  decode slot holds a real instruction
id_rd_i  in  REG_AW  destination register of the decode instruction
id_wen_i  in  1  decode instruction writes rd
id_wbsel_i  in  2  write-back source: 0 ALU, 1 MEM, 2 PC+4, 3 reserved (treated as ALU)
id_pc_i  in  XLEN  PC of the decode instruction
id_rs1_i  in  REG_AW  decode source A address (same value as AddrA_i)
id_rs2_i  in  REG_AW  decode source B address (same value as AddrB_i)
ex_alu_i  in  XLEN  ALU result of the EX-stage instruction, valid the same cycle
mem_rdata_i  in  XLEN  load data of the MEM-stage instruction, valid the same cycle
AddrD_o  out  REG_AW  regfile write address
DataD_o  out  XLEN  regfile write data
RegWEn_o  out  1  regfile write enable
fwd_a_en_o  out  1  use fwd_a_o instead of DataA
fwd_a_o  out  XLEN  bypass data for source A
fwd_b_en_o  out  1  use fwd_b_o instead of DataB
fwd_b_o  out  XLEN  bypass data for source B
load_use_o  out  1  decode must stall one cycle

Behaviour:
- Stages: EX, MEM and WB registers. Each holds {valid, rd, wen, wbsel, pc4, data}. Decode is not registered.
- Reset: every stage valid=0. AddrD_o=0, DataD_o=0, RegWEn_o=0, all fwd outputs 0, load_use_o=0.
- Advance on each edge:
  - EX <- decode fields, with pc4=id_pc_i+4 (mod 2^XLEN).
  - MEM <- EX, with data=ex_alu_i.
  - WB <- MEM, with data = mem_rdata_i if wbsel=MEM, pc4 if wbsel=PC+4, else the registered ALU data.
- Bubble into EX (valid=0) when stall_i, flush_i or !id_valid_i.
- flush_i also writes a bubble into MEM, killing the EX instruction.
- stall_i and flush_i together: same as flush_i alone.
- stall_i does not freeze EX, MEM or WB.
- Write port (combinational from the WB register):
  - RegWEn_o = WB.valid & WB.wen & (WB.rd != 0).
  - AddrD_o = WB.rd, DataD_o = WB.data.
  - Latency: an instruction decoded in cycle N has RegWEn_o high in cycle N+3; the regfile captures it at the end of N+3.
- Forwarding for each source s (rs1 -> A, rs2 -> B), fully combinational:
  - A stage matches when stage.valid & stage.wen & stage.rd == s & s != 0.
  - Priority EX > MEM > WB.
  - EX match: data = pc4 if wbsel=PC+4, else ex_alu_i.
  - MEM match: data = mem_rdata_i if wbsel=MEM, pc4 if PC+4, else the registered ALU data.
  - WB match: data = DataD_o. This covers the regfile same-cycle read-before-write.
  - No match: fwd_en=0, fwd data=0.
  - rs=0 never forwards.
- Load-use: load_use_o = id_valid_i & EX match on rs1 or rs2 with EX.wbsel=MEM.
  - fwd_en stays 1 for that source; the consumer must stall.
  - The block does not self-stall; the hazard unit drives stall_i from load_use_o.
- rd=0 with wen=1: travels down the pipe but never writes and never forwards.
- Reset mid-flight: all in-flight instructions are discarded; no write is emitted in the cycle after reset.

Decomposition:
- riscv_pkg: wb_sel_t enum (WB_ALU, WB_MEM, WB_PC4), XLEN and REG_AW constants, packed struct stage_t {valid, rd, wen, wbsel, pc4, data}.
- Sub-module riscv_fwd_mux: one instance per source. Inputs are the three stage_t values, ex_alu_i, mem_rdata_i and the source address; outputs are fwd_en, fwd data and the load-use bit.

Test Plan:
- Latency: decode rd=2, wen=1, ALU; ex_alu_i=16 next cycle -> three cycles after decode RegWEn_o=1, AddrD_o=2, DataD_o=16; the regfile then reads R2=16.
- Back-to-back EX forward: instr0 rd=8, ALU=18; next cycle decode rs1=8, rs2=8 -> fwd_a_en_o=fwd_b_en_o=1, fwd_a_o=fwd_b_o=18, load_use_o=0.
- Priority: rd=5 written with 10 (now in MEM) and 20 (now in EX), decode rs1=5 -> fwd_a_o=20; one cycle later (stall, bubble) -> 20 via MEM.
- Load-use: load rd=3 in EX, decode rs2=3 -> load_use_o=1. Drive stall_i; next cycle mem_rdata_i=0xCAFE -> fwd_b_o=0xCAFE, load_use_o=0.
- x0 and flush: rd=0, wen=1, data=99 -> RegWEn_o stays 0 and rs1=0 never forwards. flush_i with rd=4 in EX and rd=6 in ID -> neither is ever written.
- PC+4 and reset: JAL with pc=0x100, rd=1 -> DataD_o=0x104 at N+3. rst_i asserted at N+1 -> RegWEn_o=0 and all outputs 0 from the next edge.
